timer_cmd_serializer: RTL and testbench

Upstream command stage for advanced_timer_simple. Accepts a parallel 4-bit delay command over a valid/ready handshake and serialises the 1101 start pattern plus the delay bits (MSB first) onto the timer's `data` input. It then watches `counting` and `done`, returns `ack` to the timer, and reports completion or a start timeout to the host.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_cmd_serializer_if.sv | 19 +
 rtl/timer_cmd_serializer_piso_shift.sv | 59 +++++
 rtl/timer_cmd_serializer.sv | 146 ++++++++++++++
 tb/tb_timer_cmd_serializer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Constants and types shared by timer_cmd_serializer and advanced_timer_simple.
//   PATTERN         : start pattern the timer searches for (sent MSB first)
//   DELAY_W         : width of the delay field the timer reads after PATTERN
//   CYCLES_PER_UNIT : timer clock cycles per delay unit
//   state_e         : command serializer FSM states
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam logic [3:0] PATTERN         = 4'b1101;
  localparam int         DELAY_W         = 4;
  localparam int         CYCLES_PER_UNIT = 1000;
  localparam int         FRAME_W         = 4 + DELAY_W;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    ACK        = 3'd4,
    GAP        = 3'd5
  } state_e;

endpackage

// File: rtl/timer_cmd_serializer_if.sv
// ---------------------------------------------------------------------------
// timer_cmd_serializer_if
// Host command handshake.
//   cmd_valid : host presents a command
//   cmd_delay : delay value, sampled on the accepting edge only
//   cmd_ready : serializer can accept (high only while idle)
// master = host side, slave = serializer side.
// ---------------------------------------------------------------------------
interface timer_cmd_serializer_if;
  import timer_pkg::*;

  logic               cmd_valid;
  logic [DELAY_W-1:0] cmd_delay;
  logic               cmd_ready;

  modport master (output cmd_valid, output cmd_delay, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_delay, output cmd_ready);

endinterface

// File: rtl/timer_cmd_serializer_piso_shift.sv
// ---------------------------------------------------------------------------
// piso_shift
// Parallel-load, serial-out, MSB-first shift register with a bit counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture pdata, clear the bit counter
//   shift      : advance one bit (zeros enter at the LSB)
//   pdata      : parallel word
//   sout       : current serial bit (a flop output)
//   last       : the bit on sout is the final bit of the word
// Zeros are shifted in, so sout falls back to 0 once the word has gone out.
// ---------------------------------------------------------------------------
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pdata,
  output logic         sout,
  output logic         last
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // next-state for the shift register and bit counter
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = pdata;
      cnt_d = '0;
    end else if (shift) begin
      sr_d  = {sr_q[W-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sout = sr_q[W-1];
  assign last = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/timer_cmd_serializer.sv
// ---------------------------------------------------------------------------
// timer_cmd_serializer
// Accepts a delay command, streams {PATTERN, delay} MSB first onto the
// timer data input, waits for counting/done, acknowledges, then enforces an
// idle gap before the next command.
//   clk, reset  : clock, synchronous active-high reset
//   cmd_if      : host handshake (slave modport)
//   data        : serial stream to the timer (registered, 0 outside SHIFT)
//   ack         : acknowledge to the timer (registered, only in ACK)
//   counting    : timer counting status
//   done        : timer done status
//   busy        : high in every state except IDLE
//   cmd_done    : one-cycle pulse on normal completion
//   err_timeout : one-cycle pulse when counting did not start in time
// ---------------------------------------------------------------------------
module timer_cmd_serializer #(
  parameter logic [3:0] PATTERN       = timer_pkg::PATTERN,
  parameter int         START_TIMEOUT = 4,
  parameter int         GAP_CYCLES    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  timer_cmd_serializer_if.slave   cmd_if,
  output logic                    data,
  output logic                    ack,
  input  logic                    counting,
  input  logic                    done,
  output logic                    busy,
  output logic                    cmd_done,
  output logic                    err_timeout
);
  import timer_pkg::*;

  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ack_q, ack_d;
  logic          cmd_done_q, cmd_done_d;
  logic          err_q, err_d;
  logic          ready_s, accept_s, shift_s, sout_s, last_s;

  assign ready_s  = (state_q == IDLE);
  assign accept_s = cmd_if.cmd_valid & ready_s;
  assign shift_s  = (state_q == SHIFT);

  piso_shift #(.W(FRAME_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept_s),
    .shift (shift_s),
    .pdata ({PATTERN, cmd_if.cmd_delay}),
    .sout  (sout_s),
    .last  (last_s)
  );

  // FSM next-state, counters and registered-output next values
  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    gap_d      = '0;
    ack_d      = 1'b0;
    cmd_done_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = SHIFT;
        else          state_d = IDLE;
      end
      SHIFT: begin
        if (last_s) state_d = WAIT_START;
        else        state_d = SHIFT;
      end
      WAIT_START: begin
        // counting has priority over both error causes in the same cycle;
        // counting may rise in any of the first START_TIMEOUT cycles here
        if (counting) begin
          state_d = WAIT_DONE;
        end else if (done || (tmo_q >= TW'(START_TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          tmo_d   = (tmo_q >= TW'(START_TIMEOUT)) ? tmo_q : (tmo_q + TW'(1));
          state_d = WAIT_START;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      ACK: begin
        if (done) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cmd_done_d = 1'b1;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (gap_q >= GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d   = (gap_q >= GW'(GAP_CYCLES)) ? gap_q : (gap_q + GW'(1));
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      gap_q      <= '0;
      ack_q      <= 1'b0;
      cmd_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      cmd_done_q <= cmd_done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_if.cmd_ready = ready_s;
  assign data             = sout_s;
  assign ack              = ack_q;
  assign busy             = ~ready_s;
  assign cmd_done         = cmd_done_q;
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_timer_cmd_serializer.sv
module tb_timer_cmd_serializer;
  import timer_pkg::*;

  localparam int EV_BITS = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;
  localparam int NONE    = -1;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data, ack, busy, cmd_done, err_timeout, counting, done;
  logic model_en = 1'b0, stub_counting = 1'b0, stub_done = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  timer_cmd_serializer_if cmd_if();

  timer_cmd_serializer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_if      (cmd_if),
    .data        (data),
    .ack         (ack),
    .counting    (counting),
    .done        (done),
    .busy        (busy),
    .cmd_done    (cmd_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural timer: search PATTERN, read DELAY_W bits, count, hold done until ack
  int         m_st;
  int         m_nb;
  int         m_cnt;
  logic [3:0] m_hist, m_dly;
  logic       m_counting, m_done;

  always @(posedge clk) begin
    if (reset || !model_en) begin
      m_st <= 0; m_nb <= 0; m_cnt <= 0; m_hist <= 4'h0; m_dly <= 4'h0;
      m_counting <= 1'b0; m_done <= 1'b0;
    end else begin
      case (m_st)
        0: begin
          m_hist <= {m_hist[2:0], data};
          if ({m_hist[2:0], data} == PATTERN) begin m_st <= 1; m_nb <= 0; end
        end
        1: begin
          m_dly <= {m_dly[2:0], data};
          m_nb  <= m_nb + 1;
          if (m_nb == 3) begin
            m_st <= 2;
            m_counting <= 1'b1;
            m_cnt <= (int'({m_dly[2:0], data}) + 1) * CYCLES_PER_UNIT - 1;
          end
        end
        2: begin
          if (m_cnt == 0) begin m_counting <= 1'b0; m_done <= 1'b1; m_st <= 3; end
          else m_cnt <= m_cnt - 1;
        end
        default: begin
          if (ack) begin m_done <= 1'b0; m_st <= 0; m_hist <= 4'h0; end
        end
      endcase
    end
  end

  assign counting = model_en ? m_counting : stub_counting;
  assign done     = model_en ? m_done     : stub_done;

  task automatic sb_check(input int kind, input logic [7:0] val);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected t=%0t got kind=%0d val=%h, required no event", $time, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_fail++;
        $display("FAIL sb_event t=%0t got kind=%0d val=%h, required kind=%0d val=%h",
                 $time, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: collect the 8 serial bits after each accept and every pulse, compare to queue
  bit         win = 1'b0;
  int         cap_n = 0;
  logic [7:0] cap = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      win = 1'b0;
    end else begin
      if (win) begin
        cap = {cap[6:0], data};
        cap_n++;
        if (cap_n == 8) begin
          win = 1'b0;
          sb_check(EV_BITS, cap);
        end
      end else begin
        n_checks++;
        if (data !== 1'b0) begin
          n_fail++;
          $display("FAIL data_idle t=%0t got %b required 0", $time, data);
        end
      end
      if (cmd_done === 1'b1)    sb_check(EV_DONE, 8'h00);
      if (err_timeout === 1'b1) sb_check(EV_ERR, 8'h00);
      if (cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_ready === 1'b1) begin
        win = 1'b1; cap_n = 0; cap = 8'h00;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d required %0d", nm, $time, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Present a command, expect it to be accepted on this edge; returns in cycle 1 after accept
  task automatic issue(input logic [3:0] d, input bit push_bits, input int tail, input bit hold);
    chk("issue_ready", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_delay = d;
    if (push_bits)    push(EV_BITS, {PATTERN, d});
    if (tail != NONE) push(tail, 8'h00);
    tick();
    if (!hold) cmd_if.cmd_valid = 1'b0;
    chk("issue_busy", busy, 1);
    chk("issue_ready_low", cmd_if.cmd_ready, 0);
  endtask

  // Tick until cmd_done (or err_timeout) is seen, bounded; counts ticks and ack-high cycles
  task automatic wait_pulse(input int bound, input bit want_err, output int n, output int ackc);
    n = 0;
    ackc = 0;
    do begin
      tick();
      n++;
      if (ack === 1'b1) ackc++;
    end while (((want_err ? err_timeout : cmd_done) !== 1'b1) && n < bound);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_data"}, data, 0);
    chk({nm, "_ack"}, ack, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ready"}, cmd_if.cmd_ready, 1);
    chk({nm, "_cmd_done"}, cmd_done, 0);
    chk({nm, "_err"}, err_timeout, 0);
  endtask

  initial begin
    int n, ackc;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_delay = 4'h0;

    // 1: reset, then delay=1 against the behavioural timer
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals("t1_reset");
    reset = 1'b0;
    model_en = 1'b1;
    issue(4'd1, 1'b1, EV_DONE, 1'b0);
    wait_pulse(5000, 1'b0, n, ackc);
    chk("t1_done_latency", n, 2011);
    chk("t1_ack_cycles", ackc, 2);
    chk("t1_gap0_busy", busy, 1);
    tick();
    chk("t1_gap1_busy", busy, 1);
    tick();
    chk("t1_idle_busy", busy, 0);

    // 2: delay=15 with valid held; next command (delay=6) accepted after the gap
    issue(4'd15, 1'b1, EV_DONE, 1'b1);
    cmd_if.cmd_delay = 4'd6;
    push(EV_BITS, {PATTERN, 4'd6});
    push(EV_DONE, 8'h00);
    wait_pulse(20000, 1'b0, n, ackc);
    chk("t2_done_latency", n, 16011);
    chk("t2_ack_cycles", ackc, 2);
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 10) begin tick(); n++; end
    chk("t2_ready_after_done", n, 2);
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("t2_second_accept_busy", busy, 1);
    wait_pulse(10000, 1'b0, n, ackc);
    chk("t2b_done_latency", n, 7011);
    repeat (2) tick();

    // 3: valid pulsed in SHIFT and in WAIT_DONE is ignored
    issue(4'd2, 1'b1, EV_DONE, 1'b0);
    repeat (2) tick();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_delay = 4'd9;
    chk("t3_shift_ready", cmd_if.cmd_ready, 0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    repeat (50) tick();
    cmd_if.cmd_valid = 1'b1;
    chk("t3_wait_ready", cmd_if.cmd_ready, 0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    wait_pulse(5000, 1'b0, n, ackc);
    chk("t3_done_latency", n, 2957);
    repeat (2) tick();
    chk("t3_idle_ready", cmd_if.cmd_ready, 1);

    // 4: counting stuck low -> err_timeout, no ack, no cmd_done
    model_en = 1'b0;
    stub_counting = 1'b0;
    stub_done = 1'b0;
    issue(4'd3, 1'b1, EV_ERR, 1'b0);
    wait_pulse(50, 1'b1, n, ackc);
    chk("t4_err_latency", n, 12);
    chk("t4_ack_cycles", ackc, 0);
    repeat (2) tick();
    chk("t4_idle_busy", busy, 0);

    // 5a: reset during SHIFT bit 3
    model_en = 1'b1;
    issue(4'd7, 1'b0, NONE, 1'b0);
    repeat (4) tick();
    chk("t5_mid_shift_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals("t5_shift_rst");
    reset = 1'b0;
    tick();

    // 5b: reset during ACK
    model_en = 1'b0;
    stub_counting = 1'b1;
    issue(4'd0, 1'b1, NONE, 1'b0);
    repeat (9) tick();
    stub_done = 1'b1;
    tick();
    chk("t5_ack_high", ack, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals("t5_ack_rst");
    reset = 1'b0;
    stub_done = 1'b0;
    stub_counting = 1'b0;
    tick();
    model_en = 1'b1;
    issue(4'd0, 1'b1, EV_DONE, 1'b0);
    wait_pulse(3000, 1'b0, n, ackc);
    chk("t5_recover_latency", n, 1011);
    repeat (2) tick();

    // 6: stub holds done for 3 cycles (cycles 12..14 after accept)
    model_en = 1'b0;
    stub_counting = 1'b1;
    issue(4'd2, 1'b1, EV_DONE, 1'b0);
    repeat (11) tick();
    for (int i = 12; i <= 17; i++) begin
      stub_done = (i <= 14);
      chk($sformatf("t6_ack_c%0d", i), ack, ((i >= 13) && (i <= 15)) ? 1 : 0);
      chk($sformatf("t6_cmd_done_c%0d", i), cmd_done, (i == 16) ? 1 : 0);
      tick();
    end
    chk("t6_idle_ready", cmd_if.cmd_ready, 1);
    stub_counting = 1'b0;

    repeat (3) tick();
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
